// File: rtl/msi_cache_array.sv
// N-way set-associative L1 line store with LRU victim choice and a registered snoop port.
// Build option MSI_CACHE_MESI_EN keeps EXCLUSIVE lines; without it EXCLUSIVE folds into SHARED.
package msi_cache_pkg;
    typedef enum logic [1:0] {
        INVALID   = 2'b00,
        SHARED    = 2'b01,
        EXCLUSIVE = 2'b10,
        MODIFIED  = 2'b11
    } blk_state_t;
endpackage

module msi_cache_array
    import msi_cache_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int SETS   = 64,
    parameter int WAYS   = 2,
    parameter int LINE_W = 64,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = ADDR_W - IDX_W,
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              re,
    input  logic              we,
    input  logic [LINE_W-1:0] wr_data,
    input  blk_state_t        wstate,
    output logic              ready,
    output logic              rd_valid,
    output logic              hit,
    output logic [WAY_W-1:0]  hit_way,
    output blk_state_t        rstate,
    output logic [LINE_W-1:0] rd_data,
    output logic [TAG_W-1:0]  tag_out,
    output logic              dirty,
    input  logic              snp_req,
    input  logic [ADDR_W-1:0] snp_addr,
    input  logic [1:0]        snp_op,
    output logic              snp_ack,
    output logic              snp_hit,
    output blk_state_t        snp_state,
    output logic [LINE_W-1:0] snp_data,
    output logic [1:0]        dbg_state
);

    // Handshake: a core request (re or we) is taken on a rising edge where ready=1;
    // ready is high only in IDLE with no snoop pending, so snoops always win.
    typedef enum logic [1:0] {S_IDLE, S_CPU_RSP, S_SNP_RSP} fsm_t;

    fsm_t state, next_state;

    blk_state_t        st_mem   [WAYS][SETS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0] data_mem [WAYS][SETS];
    logic [2:0]        lru_mem  [SETS];

    logic [ADDR_W-1:0] req_addr, snp_addr_q, look_addr;
    logic [1:0]        snp_op_q;
    logic [IDX_W-1:0]  w_idx, look_idx;
    logic [TAG_W-1:0]  w_tag, look_tag, look_tagv;
    logic [WAY_W-1:0]  w_way, look_way;
    blk_state_t        w_state, look_line_state, look_state;
    logic              wr_en, look_hit, look_dirty;
    logic [LINE_W-1:0] look_data;

    logic              hit_q, dirty_q, snp_hit_q;
    logic [WAY_W-1:0]  hit_way_q;
    blk_state_t        rstate_q, snp_state_q;
    logic [LINE_W-1:0] rd_data_q, snp_data_q;
    logic [TAG_W-1:0]  tag_out_q;

    // LRU bits name the way to evict; 4-way uses a tree (bit0 picks the half).
    function automatic logic [WAY_W-1:0] lru_victim(input logic [2:0] bits);
        logic [1:0] v;
        if (WAYS == 4)      v = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
        else if (WAYS == 2) v = {1'b0, bits[0]};
        else                v = 2'b00;
        return WAY_W'(v);
    endfunction

    function automatic logic [2:0] lru_touch(input logic [2:0] bits, input logic [WAY_W-1:0] way);
        logic [1:0] w;
        logic [2:0] n;
        w = 2'(way);
        n = bits;
        if (WAYS == 4) begin
            n[0] = ~w[1];
            if (w[1]) n[2] = ~w[0];
            else      n[1] = ~w[0];
        end else if (WAYS == 2) begin
            n = {2'b00, ~w[0]};
        end else begin
            n = 3'b000;
        end
        return n;
    endfunction

    function automatic logic line_hit(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag);
        logic m;
        m = 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (st_mem[w][idx] != INVALID && tag_mem[w][idx] == tag) m = 1'b1;
        return m;
    endfunction

    // Matching valid way, else lowest INVALID way, else the LRU way.
    function automatic logic [WAY_W-1:0] pick_way(input logic [IDX_W-1:0] idx,
                                                  input logic [TAG_W-1:0] tag);
        logic             inv_found, m_found;
        logic [WAY_W-1:0] inv_way, m_way, way;
        inv_found = 1'b0;
        m_found   = 1'b0;
        inv_way   = '0;
        m_way     = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (st_mem[w][idx] == INVALID) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end else if (tag_mem[w][idx] == tag) begin
                m_found = 1'b1;
                m_way   = WAY_W'(w);
            end
        end
        way = lru_victim(lru_mem[idx]);
        if (inv_found) way = inv_way;
        if (m_found)   way = m_way;
        return way;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            S_IDLE: begin
                if (snp_req) begin
                    next_state = S_SNP_RSP;
                end else begin
                    ready = 1'b1;
                    if (re) next_state = S_CPU_RSP;
                end
            end
            S_CPU_RSP: next_state = S_IDLE;
            S_SNP_RSP: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    assign dbg_state = state;
    // Writes act only on an accepted cycle, so a we held through a snoop or response is ignored.
    assign wr_en     = ready && we;

    always_comb begin
        w_idx = addr[IDX_W-1:0];
        w_tag = addr[ADDR_W-1:IDX_W];
        w_way = pick_way(w_idx, w_tag);
`ifdef MSI_CACHE_MESI_EN
        w_state = wstate;
`else
        w_state = (wstate == EXCLUSIVE) ? SHARED : wstate;
`endif
    end

    always_comb begin
        look_addr       = (state == S_SNP_RSP) ? snp_addr_q : req_addr;
        look_idx        = look_addr[IDX_W-1:0];
        look_tag        = look_addr[ADDR_W-1:IDX_W];
        look_hit        = line_hit(look_idx, look_tag);
        look_way        = pick_way(look_idx, look_tag);
        look_line_state = st_mem[look_way][look_idx];
        look_state      = look_hit ? look_line_state : INVALID;
        look_data       = data_mem[look_way][look_idx];
        look_tagv       = tag_mem[look_way][look_idx];
        look_dirty      = !look_hit && (look_line_state == MODIFIED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr   <= '0;
            snp_addr_q <= '0;
            snp_op_q   <= '0;
        end else begin
            if (ready && re)                 req_addr <= addr;
            if (state == S_IDLE && snp_req) begin
                snp_addr_q <= snp_addr;
                snp_op_q   <= snp_op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    st_mem[w][s] <= INVALID;
        end else if (wr_en) begin
            st_mem[w_way][w_idx] <= w_state;
        end else if (state == S_SNP_RSP && look_hit) begin
            case (snp_op_q)
                2'b01: if (look_line_state == MODIFIED || look_line_state == EXCLUSIVE)
                           st_mem[look_way][look_idx] <= SHARED;
                2'b10: st_mem[look_way][look_idx] <= INVALID;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[w_way][w_idx]  <= w_tag;
            data_mem[w_way][w_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) lru_mem[s] <= 3'b000;
        end else if (wr_en) begin
            lru_mem[w_idx] <= lru_touch(lru_mem[w_idx], w_way);
        end else if (state == S_CPU_RSP && look_hit) begin
            lru_mem[look_idx] <= lru_touch(lru_mem[look_idx], look_way);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q       <= 1'b0;
            hit_way_q   <= '0;
            rstate_q    <= INVALID;
            rd_data_q   <= '0;
            tag_out_q   <= '0;
            dirty_q     <= 1'b0;
            snp_hit_q   <= 1'b0;
            snp_state_q <= INVALID;
            snp_data_q  <= '0;
        end else begin
            if (state == S_CPU_RSP) begin
                hit_q     <= look_hit;
                hit_way_q <= look_way;
                rstate_q  <= look_state;
                rd_data_q <= look_data;
                tag_out_q <= look_tagv;
                dirty_q   <= look_dirty;
            end
            if (state == S_SNP_RSP) begin
                snp_hit_q   <= look_hit;
                snp_state_q <= look_state;
                snp_data_q  <= look_data;
            end
        end
    end

    // Responses are live during their pulse cycle and held afterwards.
    always_comb begin
        rd_valid  = (state == S_CPU_RSP);
        snp_ack   = (state == S_SNP_RSP);
        hit       = rd_valid ? look_hit   : hit_q;
        hit_way   = rd_valid ? look_way   : hit_way_q;
        rstate    = rd_valid ? look_state : rstate_q;
        rd_data   = rd_valid ? look_data  : rd_data_q;
        tag_out   = rd_valid ? look_tagv  : tag_out_q;
        dirty     = rd_valid ? look_dirty : dirty_q;
        snp_hit   = snp_ack  ? look_hit   : snp_hit_q;
        snp_state = snp_ack  ? look_state : snp_state_q;
        snp_data  = snp_ack  ? look_data  : snp_data_q;
    end

endmodule

// File: tb/tb_msi_cache_array.sv
// Self-checking bench for msi_cache_array: directed steps plus random traffic against a
// timestamp-based LRU reference model.
module tb_msi_cache_array;
    import msi_cache_pkg::*;

    localparam int ADDR_W = 11;
    localparam int SETS   = 64;
    localparam int WAYS   = 2;
    localparam int LINE_W = 64;
    localparam int IDX_W  = 6;
    localparam int TAG_W  = 5;
    localparam int WAY_W  = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              re = 1'b0;
    logic              we = 1'b0;
    logic [LINE_W-1:0] wr_data = '0;
    blk_state_t        wstate = INVALID;
    logic              ready, rd_valid, hit, dirty;
    logic [WAY_W-1:0]  hit_way;
    blk_state_t        rstate, snp_state;
    logic [LINE_W-1:0] rd_data, snp_data;
    logic [TAG_W-1:0]  tag_out;
    logic              snp_req = 1'b0;
    logic [ADDR_W-1:0] snp_addr = '0;
    logic [1:0]        snp_op = '0;
    logic              snp_ack, snp_hit;
    logic [1:0]        dbg_state;

    msi_cache_array #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we), .wr_data(wr_data),
        .wstate(wstate), .ready(ready), .rd_valid(rd_valid), .hit(hit), .hit_way(hit_way),
        .rstate(rstate), .rd_data(rd_data), .tag_out(tag_out), .dirty(dirty),
        .snp_req(snp_req), .snp_addr(snp_addr), .snp_op(snp_op), .snp_ack(snp_ack),
        .snp_hit(snp_hit), .snp_state(snp_state), .snp_data(snp_data), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: per-line contents plus a last-use timestamp for true LRU.
    blk_state_t        m_st   [WAYS][SETS];
    logic [TAG_W-1:0]  m_tag  [WAYS][SETS];
    logic [LINE_W-1:0] m_data [WAYS][SETS];
    int                m_used [WAYS][SETS];
    int                tick;
    logic [LINE_W-1:0] exp_q[$];
    int                n_assert = 0;
    int                n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                m_st[w][s]   = INVALID;
                m_used[w][s] = 0;
            end
        tick = 0;
    endtask

    function automatic int m_find(input int idx, input logic [TAG_W-1:0] t);
        for (int w = 0; w < WAYS; w++)
            if (m_st[w][idx] != INVALID && m_tag[w][idx] == t) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int idx);
        int best;
        for (int w = 0; w < WAYS; w++)
            if (m_st[w][idx] == INVALID) return w;
        best = 0;
        for (int w = 1; w < WAYS; w++)
            if (m_used[w][idx] < m_used[best][idx]) best = w;
        return best;
    endfunction

    function automatic blk_state_t m_fold(input blk_state_t s);
`ifdef MSI_CACHE_MESI_EN
        return s;
`else
        return (s == EXCLUSIVE) ? SHARED : s;
`endif
    endfunction

    task automatic m_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d, input blk_state_t s);
        int idx, w;
        logic [TAG_W-1:0] t;
        idx = int'(a[IDX_W-1:0]);
        t   = a[ADDR_W-1:IDX_W];
        w   = m_find(idx, t);
        if (w < 0) w = m_victim(idx);
        m_st[w][idx]   = m_fold(s);
        m_tag[w][idx]  = t;
        m_data[w][idx] = d;
        tick++;
        m_used[w][idx] = tick;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 8 && !ready; i++) begin
            @(posedge clk);
            #1;
        end
        check({tag, ".ready"}, ready, 1);
    endtask

    // Checks the response visible one cycle after a lookup was accepted, then steps to IDLE.
    task automatic check_rsp(input logic [ADDR_W-1:0] a, input string tag);
        int idx, w, v;
        logic [TAG_W-1:0] t;
        logic exp_hit;
        idx = int'(a[IDX_W-1:0]);
        t   = a[ADDR_W-1:IDX_W];
        w   = m_find(idx, t);
        exp_hit = (w >= 0);
        check({tag, ".rd_valid"}, rd_valid, 1);
        check({tag, ".hit"}, hit, exp_hit);
        if (exp_hit) begin
            exp_q.push_back(m_data[w][idx]);
            check({tag, ".hit_way"}, hit_way, w);
            check({tag, ".rstate"}, rstate, m_st[w][idx]);
            check({tag, ".rd_data"}, rd_data, exp_q.pop_front());
            check({tag, ".dirty"}, dirty, 0);
            tick++;
            m_used[w][idx] = tick;
        end else begin
            v = m_victim(idx);
            check({tag, ".victim"}, hit_way, v);
            check({tag, ".rstate"}, rstate, INVALID);
            check({tag, ".dirty"}, dirty, m_st[v][idx] == MODIFIED);
            if (m_st[v][idx] != INVALID) check({tag, ".tag_out"}, tag_out, m_tag[v][idx]);
        end
        @(posedge clk);
        #1;
        check({tag, ".rd_valid_drop"}, rd_valid, 0);
        check({tag, ".hit_hold"}, hit, exp_hit);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                            input blk_state_t s, input string tag);
        wait_ready(tag);
        addr = a; wr_data = d; wstate = s; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        m_write(a, d, s);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input string tag);
        wait_ready(tag);
        addr = a; re = 1'b1;
        @(posedge clk);
        #1;
        re = 1'b0;
        check_rsp(a, tag);
    endtask

    task automatic snoop_rsp(input logic [ADDR_W-1:0] a, input logic [1:0] op, input string tag);
        int idx, w;
        logic [TAG_W-1:0] t;
        idx = int'(a[IDX_W-1:0]);
        t   = a[ADDR_W-1:IDX_W];
        w   = m_find(idx, t);
        check({tag, ".snp_ack"}, snp_ack, 1);
        check({tag, ".snp_hit"}, snp_hit, w >= 0);
        if (w >= 0) begin
            check({tag, ".snp_state"}, snp_state, m_st[w][idx]);
            check({tag, ".snp_data"}, snp_data, m_data[w][idx]);
            if (op == 2'b01 && (m_st[w][idx] == MODIFIED || m_st[w][idx] == EXCLUSIVE))
                m_st[w][idx] = SHARED;
            else if (op == 2'b10)
                m_st[w][idx] = INVALID;
        end else begin
            check({tag, ".snp_state"}, snp_state, INVALID);
        end
    endtask

    task automatic do_snoop(input logic [ADDR_W-1:0] a, input logic [1:0] op, input string tag);
        snp_addr = a; snp_op = op; snp_req = 1'b1;
        #1;
        check({tag, ".ready_low"}, ready, 0);
        @(posedge clk);
        #1;
        snp_req = 1'b0;
        snoop_rsp(a, op, tag);
        @(posedge clk);
        #1;
        check({tag, ".snp_ack_drop"}, snp_ack, 0);
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.rd_valid", rd_valid, 0);
        check("reset.snp_ack", snp_ack, 0);
        check("reset.hit", hit, 0);
        check("reset.dirty", dirty, 0);
        check("reset.snp_hit", snp_hit, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_read(11'h040, "cold");
        do_write(11'h045, 64'hDEAD_BEEF_0123_4567, MODIFIED, "w045");
        do_read(11'h045, "r045");
        do_read(11'h085, "r085_miss");
        do_write(11'h085, 64'h1111_2222_3333_4444, SHARED, "w085");
        do_read(11'h045, "r045_lru");
        do_read(11'h0C5, "r0c5_victim");
        do_snoop(11'h045, 2'b01, "snp_dg");
        do_read(11'h045, "r045_shared");
        do_write(11'h0C5, 64'hCAFE_F00D_5555_6666, EXCLUSIVE, "w0c5_excl");
        do_read(11'h0C5, "r0c5_excl");
        do_snoop(11'h1C5, 2'b00, "snp_miss");
        do_snoop(11'h085, 2'b11, "snp_rsvd");

        // Snoop and lookup raised together: the snoop goes first, the read is retried.
        snp_addr = 11'h045; snp_op = 2'b10; snp_req = 1'b1;
        addr = 11'h045; re = 1'b1;
        #1;
        check("race.ready_low", ready, 0);
        @(posedge clk);
        #1;
        snp_req = 1'b0;
        snoop_rsp(11'h045, 2'b10, "race");
        check("race.no_rsp", rd_valid, 0);
        @(posedge clk);
        #1;
        check("race.retry_ready", ready, 1);
        @(posedge clk);
        #1;
        re = 1'b0;
        check_rsp(11'h045, "race_rd");

        // Write and lookup in one cycle return the freshly written line.
        addr = 11'h087; wr_data = 64'h0F0F_A5A5_1234_9876; wstate = MODIFIED;
        we = 1'b1; re = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0;
        m_write(11'h087, 64'h0F0F_A5A5_1234_9876, MODIFIED);
        check_rsp(11'h087, "wr_rd");

        // Reset asserted mid-response.
        addr = 11'h087; re = 1'b1;
        @(posedge clk);
        #1;
        re = 1'b0;
        check("rst_mid.rd_valid_pre", rd_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.rd_valid", rd_valid, 0);
        check("rst_mid.hit", hit, 0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_read(11'h087, "post_rst_087");
        do_read(11'h0C5, "post_rst_0c5");

        for (int i = 0; i < 300; i++) begin
            logic [ADDR_W-1:0] a;
            a = {TAG_W'($urandom_range(0, 3)), IDX_W'($urandom_range(5, 7))};
            case ($urandom_range(0, 2))
                0: do_write(a, {$urandom, $urandom}, blk_state_t'($urandom_range(0, 3)), "rnd_w");
                1: do_read(a, "rnd_r");
                default: do_snoop(a, 2'($urandom_range(0, 3)), "rnd_s");
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
